// File: rtl/spi_host_frame_driver_if.sv
// spi_host_frame_driver_if: command/response word stream between a client and the SPI frame driver
interface spi_host_frame_driver_if #(parameter int WORD_WIDTH = 64);
    logic tx_valid, tx_ready, tx_last, rx_valid, abort, busy;
    logic [WORD_WIDTH-1:0] tx_data, rx_data;
    modport master (output tx_valid, tx_data, tx_last, abort, input tx_ready, rx_valid, rx_data, busy);
    modport slave (input tx_valid, tx_data, tx_last, abort, output tx_ready, rx_valid, rx_data, busy);
endinterface

// File: rtl/spi_host_frame_driver.sv
// spi_host_frame_driver: mode-0 MSB-first SPI host that frames streamed command words under one CS assertion
module spi_host_frame_driver #(
    parameter int WORD_WIDTH = 64,
    parameter int CLK_DIV = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD = 2,
    parameter int CS_IDLE = 2
) (
    input  logic CLK,
    input  logic resetn_in,
    spi_host_frame_driver_if.slave bus,
    output logic SCK,
    output logic CS,
    output logic COPI,
    input  logic CIPO
);
    localparam int BW = $clog2(WORD_WIDTH);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT_NEXT, HOLD, GAP} state_t;
    state_t state;
    logic [15:0] cnt;
    logic [BW-1:0] bit_cnt;
    logic [WORD_WIDTH-1:0] tx_sr, rx_sr, rx_data;
    logic last_q, rx_valid;
    // abort wins over a handshake in WAIT_NEXT, so the word is not reported as taken
    assign bus.tx_ready = state == IDLE || (state == WAIT_NEXT && !bus.abort);
    assign bus.busy = state != IDLE;
    assign bus.rx_valid = rx_valid;
    assign bus.rx_data = rx_data;
    always_ff @(posedge CLK) begin
        if (!resetn_in) begin
            state <= IDLE;
            cnt <= '0;
            bit_cnt <= '0;
            tx_sr <= '0;
            rx_sr <= '0;
            rx_data <= '0;
            rx_valid <= 1'b0;
            last_q <= 1'b0;
            SCK <= 1'b0;
            CS <= 1'b1;
            COPI <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (bus.abort && state != IDLE) begin
                state <= GAP;
                cnt <= '0;
                SCK <= 1'b0;
                CS <= 1'b1;
                COPI <= 1'b0;
            end else begin
                case (state)
                    IDLE, WAIT_NEXT: if (bus.tx_valid) begin
                        state <= state == IDLE ? SETUP : SHIFT;
                        CS <= 1'b0;
                        COPI <= bus.tx_data[WORD_WIDTH-1];
                        tx_sr <= bus.tx_data;
                        last_q <= bus.tx_last;
                        cnt <= '0;
                        bit_cnt <= '0;
                    end
                    SETUP: begin
                        cnt <= cnt == 16'(CS_SETUP - 1) ? '0 : cnt + 16'd1;
                        if (cnt == 16'(CS_SETUP - 1)) state <= SHIFT;
                    end
                    SHIFT: if (cnt != 16'(CLK_DIV - 1)) cnt <= cnt + 16'd1;
                    else begin
                        cnt <= '0;
                        SCK <= ~SCK;
                        if (!SCK) rx_sr <= {rx_sr[WORD_WIDTH-2:0], CIPO};
                        else if (bit_cnt == BW'(WORD_WIDTH - 1)) begin
                            state <= last_q ? HOLD : WAIT_NEXT;
                            rx_data <= rx_sr;
                            rx_valid <= 1'b1;
                            COPI <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            tx_sr <= {tx_sr[WORD_WIDTH-2:0], 1'b0};
                            COPI <= tx_sr[WORD_WIDTH-2];
                        end
                    end
                    HOLD: begin
                        cnt <= cnt == 16'(CS_HOLD - 1) ? '0 : cnt + 16'd1;
                        if (cnt == 16'(CS_HOLD - 1)) begin
                            state <= GAP;
                            CS <= 1'b1;
                        end
                    end
                    GAP: begin
                        cnt <= cnt == 16'(CS_IDLE - 1) ? '0 : cnt + 16'd1;
                        if (cnt == 16'(CS_IDLE - 1)) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
